glyph_pixel_pipe: RTL
=====================

Name: glyph_pixel_pipe

Overview:
- Pipelined glyph-ROM pixel fetcher: takes a character code plus pixel/line position inside the character cell, issues the glyph ROM read, and returns one pixel bit.
- Successor to the fixed 8x8, 2-lines-per-word combinational address generator. Generalised in glyph size, lines packed per ROM word, ROM read latency and glyph count.
- Adds a valid/ready handshake with back-pressure and a per-character invert attribute.
- Sits between the text-buffer reader and the VGA pixel mux.

Parameters:
- CODE_W, 8, character code width
- GLYPH_W, 8, pixels per glyph line (power of two)
- GLYPH_H, 8, lines per glyph (power of two)
- LINES_PER_WORD, 2, glyph lines packed per ROM word (power of two, divides GLYPH_H)
- ADDR_W, 13, ROM address width; must be at least CODE_W+log2(GLYPH_H/LINES_PER_WORD)
- ROM_LAT, 1, ROM read latency in enabled cycles (1..4)
- NUM_GLYPHS, 128, glyphs present in ROM

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- in_valid, in, 1, request present
- in_ready, out, 1, request accepted when in_valid && in_ready
- ascii, in, CODE_W, character code
- pixel_count, in, log2(GLYPH_W), column inside cell, 0 = leftmost
- line_count, in, log2(GLYPH_H), row inside cell, 0 = top
- invert, in, 1, attribute: invert pixel
- rom_addr, out, ADDR_W, glyph ROM address
- rom_en, out, 1, ROM clock enable
- rom_data, in, GLYPH_W*LINES_PER_WORD, ROM word, valid ROM_LAT enabled cycles after address
- out_valid, out, 1, pixel result valid
- out_ready, in, 1, downstream accepts
- pixel, out, 1, pixel value (1 = foreground)
- bad_code, out, 1, code was >= NUM_GLYPHS

Behaviour:
- One clock; reset is synchronous and active-high. Reset clears all stage valids, out_valid, pixel and bad_code to 0.
- advance = !out_valid || out_ready. The whole pipe moves only when advance is 1.
- in_ready = advance and is 0 during reset. rom_en = advance.
- WPG = GLYPH_H/LINES_PER_WORD.
- Effective code c = ascii if ascii < NUM_GLYPHS, else 0.
- rom_addr = zero-extended c*WPG + (line_count >> log2(LINES_PER_WORD)). The multiply is a shift because WPG is a power of two.
  - rom_addr is combinational from the inputs, matching the existing address formula at default parameters.
- Sideband is carried through a ROM_LAT-deep shift pipe enabled by advance:
  - stage valid = in_valid && in_ready
  - sub-line = line_count mod LINES_PER_WORD
  - pixel_count, invert, bad flag
- Bit select inside a ROM word is MSB-first: idx = GLYPH_W*LINES_PER_WORD-1 - (sub_line*GLYPH_W + pixel_count).
- Output register, loaded on advance:
  - out_valid = last stage valid
  - pixel = rom_data[idx] ^ invert
  - bad_code = bad flag
  - If the last stage is not valid: out_valid goes to 0, and pixel and bad_code hold their values.
- Latency: with out_ready held at 1, a request accepted in cycle N gives out_valid in cycle N+ROM_LAT+1. Throughput is one pixel per cycle.
- Stall: while out_valid && !out_ready, all of the following hold stable:
  - in_ready = 0 and rom_en = 0
  - ROM output held
  - sideband and output held
  - No request is lost or duplicated, and result order equals request order.
- Bubbles (in_valid = 0) travel through as invalid stages. They do not produce out_valid.
- Reset mid-stream: all in-flight requests are discarded. The first acceptance is allowed in the cycle after reset deasserts.
- Out-of-range code: the read targets glyph 0, and bad_code = 1 accompanies that pixel only.

Test Plan:
- Defaults, ROM model with ROM_LAT=1. ascii=0x41, line_count=5, pixel_count=3, invert=0 -> rom_addr=0x106. With ROM word 0x0010, pixel=1 at cycle N+2; pixel_count=2 gives 0.
- Same request with invert=1 -> pixel=0. Streaming 8 consecutive pixel_count values with out_ready=1 -> 8 results on 8 consecutive cycles, in order.
- out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, rom_en=0, pixel stable. After release the next results follow with no loss or duplication.
- ascii=0x90 with NUM_GLYPHS=128 -> rom_addr from glyph 0 (line 0: 0x000), bad_code=1 for that result only.
- GLYPH_W=8, GLYPH_H=16, LINES_PER_WORD=4, ROM_LAT=2: ascii=0x02, line_count=9 -> rom_addr=0x00A, sub-line 1, latency 3 cycles.
- reset asserted for 1 cycle with 2 requests in flight -> out_valid=0 the next cycle, no stale results afterwards, and in_ready=1 the cycle after reset drops.

Source files
------------

// File: rtl/glyph_pixel_pipe_if.sv
// Handshake and glyph-ROM signal bundle for glyph_pixel_pipe.
// slave is the pipe's view; master is the requester/ROM/sink side.
interface glyph_pixel_pipe_if #(
  parameter int CODE_W         = 8,
  parameter int GLYPH_W        = 8,
  parameter int GLYPH_H        = 8,
  parameter int LINES_PER_WORD = 2,
  parameter int ADDR_W         = 13
);
  logic                                in_valid;
  logic                                in_ready;
  logic [CODE_W-1:0]                   ascii;
  logic [$clog2(GLYPH_W)-1:0]          pixel_count;
  logic [$clog2(GLYPH_H)-1:0]          line_count;
  logic                                invert;
  logic [ADDR_W-1:0]                   rom_addr;
  logic                                rom_en;
  logic [GLYPH_W*LINES_PER_WORD-1:0]   rom_data;
  logic                                out_valid;
  logic                                out_ready;
  logic                                pixel;
  logic                                bad_code;

  modport slave (
    input  in_valid, ascii, pixel_count, line_count, invert, rom_data, out_ready,
    output in_ready, rom_addr, rom_en, out_valid, pixel, bad_code
  );

  modport master (
    output in_valid, ascii, pixel_count, line_count, invert, rom_data, out_ready,
    input  in_ready, rom_addr, rom_en, out_valid, pixel, bad_code
  );
endinterface

// File: rtl/glyph_pixel_pipe.sv
// Pipelined glyph-ROM pixel fetcher: address generation, sideband delay line
// matching the ROM latency, and a registered pixel output with back-pressure.
module glyph_pixel_pipe #(
  parameter int CODE_W         = 8,
  parameter int GLYPH_W        = 8,
  parameter int GLYPH_H        = 8,
  parameter int LINES_PER_WORD = 2,
  parameter int ADDR_W         = 13,
  parameter int ROM_LAT        = 1,
  parameter int NUM_GLYPHS     = 128
) (
  input logic clk,
  input logic reset,
  glyph_pixel_pipe_if.slave bus
);

  localparam int PC_W  = $clog2(GLYPH_W);
  localparam int LPW_L = $clog2(LINES_PER_WORD);
  localparam int WPG_L = $clog2(GLYPH_H / LINES_PER_WORD);
  localparam int SUB_W = (LPW_L > 0) ? LPW_L : 1;
  localparam int POS_W = PC_W + LPW_L;

  logic              advance;
  logic              accept;
  logic              bad_in;
  logic [CODE_W-1:0] code_eff;
  logic [SUB_W-1:0]  sub_in;
  logic [POS_W-1:0]  pos;

  logic [ROM_LAT-1:0] st_valid;
  logic [ROM_LAT-1:0] st_inv;
  logic [ROM_LAT-1:0] st_bad;
  logic [PC_W-1:0]    st_pc  [ROM_LAT];
  logic [SUB_W-1:0]   st_sub [ROM_LAT];

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance && !reset;
  assign bus.rom_en   = advance;
  assign accept       = bus.in_valid && bus.in_ready;

  // Out-of-range codes read glyph 0 and are flagged downstream.
  assign bad_in   = 32'(bus.ascii) >= NUM_GLYPHS;
  assign code_eff = bad_in ? '0 : bus.ascii;

  // Words per glyph is a power of two, so the glyph base is a shift.
  assign bus.rom_addr = (ADDR_W'(code_eff) << WPG_L) | ADDR_W'(bus.line_count >> LPW_L);

  // Word bits are MSB-first, so the bit index is the inverted {sub_line, column}.
  if (LPW_L > 0) begin : g_sub
    assign sub_in = bus.line_count[SUB_W-1:0];
    assign pos    = {st_sub[ROM_LAT-1], st_pc[ROM_LAT-1]};
  end else begin : g_nosub
    assign sub_in = '0;
    assign pos    = st_pc[ROM_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_valid      <= '0;
      bus.out_valid <= 1'b0;
      bus.pixel     <= 1'b0;
      bus.bad_code  <= 1'b0;
    end else if (advance) begin
      st_valid[0] <= accept;
      st_inv[0]   <= bus.invert;
      st_bad[0]   <= bad_in;
      st_pc[0]    <= bus.pixel_count;
      st_sub[0]   <= sub_in;
      for (int i = 1; i < ROM_LAT; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_inv[i]   <= st_inv[i-1];
        st_bad[i]   <= st_bad[i-1];
        st_pc[i]    <= st_pc[i-1];
        st_sub[i]   <= st_sub[i-1];
      end
      bus.out_valid <= st_valid[ROM_LAT-1];
      if (st_valid[ROM_LAT-1]) begin
        bus.pixel    <= bus.rom_data[~pos] ^ st_inv[ROM_LAT-1];
        bus.bad_code <= st_bad[ROM_LAT-1];
      end
    end
  end

endmodule
